// File: rtl/alu_pkg.sv
// Shared constants, op codes and FSM states for the ALU command sequencer.
package alu_pkg;

    localparam int ALU_W = 12;

    localparam logic [2:0] OP_ABS = 3'd0;
    localparam logic [2:0] OP_SHL = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_ADD = 3'd6;
    localparam logic [2:0] OP_SUB = 3'd7;

    localparam int FLG_CARRY = 2;
    localparam int FLG_SIGN  = 1;
    localparam int FLG_OV    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        WB    = 2'd3
    } seq_state_t;

    // Op 1 (B<<1) has no A operand.
    function automatic logic op_uses_a(input logic [2:0] op);
        return op != OP_SHL;
    endfunction

    // ABS and NOT have no B operand.
    function automatic logic op_uses_b(input logic [2:0] op);
        return !(op == OP_ABS || op == OP_NOT);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, load and result signals between the command source and the sequencer.
interface alu_sequencer_if import alu_pkg::*; #(
    parameter int W    = ALU_W,
    parameter int NREG = 4
);
    localparam int AW = $clog2(NREG);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_ra;
    logic [AW-1:0] cmd_rb;

    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_data;

    logic          res_valid;
    logic [W-1:0]  res_z;
    logic [2:0]    res_flags;
    logic          ov_sticky;
    logic          ov_clr;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb,
        output ld_valid, ld_addr, ld_data, ov_clr,
        input  cmd_ready, res_valid, res_z, res_flags, ov_sticky
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb,
        input  ld_valid, ld_addr, ld_data, ov_clr,
        output cmd_ready, res_valid, res_z, res_flags, ov_sticky
    );
endinterface

// File: rtl/alu_regfile.sv
// Register file with two async read ports and two write ports; writeback beats load.
module alu_regfile import alu_pkg::*; #(
    parameter int  W    = ALU_W,
    parameter int  NREG = 4,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [W-1:0]  ra_data,
    output logic [W-1:0]  rb_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [W-1:0]  wb_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data
);
    logic [W-1:0] rf [NREG];

    // Per-entry write with writeback taking priority over a coincident load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_en && wb_addr == AW'(i))
                    rf[i] <= wb_data;
                else if (ld_en && ld_addr == AW'(i))
                    rf[i] <= ld_data;
            end
        end
    end

    assign ra_data = rf[ra_addr];
    assign rb_data = rf[rb_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven initiator for the external combinational 12-bit ALU.
//
//  state | meaning
//  IDLE  | ready for a command; accept latches op/rd/ra/rb
//  ISSUE | register op and masked operands onto the ALU bus
//  CAPT  | sample ALU result and flags into the result registers
//  WB    | write result to rd, pulse res_valid, accumulate ov_sticky
module alu_sequencer import alu_pkg::*; #(
    parameter int W    = ALU_W,
    parameter int NREG = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus,
    output logic [2:0]     alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic [W-1:0]   alu_z,
    input  logic           alu_carry,
    input  logic           alu_sign,
    input  logic           alu_ov
);
    localparam int AW = $clog2(NREG);

    seq_state_t    state, state_nxt;
    logic          accept, issue, capt, wb;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q, ra_q, rb_q;
    logic [W-1:0]  rf_a, rf_b;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and per-state strobes; one command every four cycles.
    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        accept        = 1'b0;
        issue         = 1'b0;
        capt          = 1'b0;
        wb            = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                issue     = 1'b1;
                state_nxt = CAPT;
            end
            CAPT: begin
                capt      = 1'b1;
                state_nxt = WB;
            end
            WB: begin
                wb            = 1'b1;
                bus.res_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the accepted command; addresses only, operands are read later at ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            rd_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
        end else if (accept) begin
            op_q <= bus.cmd_op;
            rd_q <= bus.cmd_rd;
            ra_q <= bus.cmd_ra;
            rb_q <= bus.cmd_rb;
        end
    end

    // Drive the ALU bus at ISSUE, zeroing operands the op does not use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
        end else if (issue) begin
            alu_op <= op_q;
            alu_a  <= op_uses_a(op_q) ? rf_a : '0;
            alu_b  <= op_uses_b(op_q) ? rf_b : '0;
        end
    end

    // Capture ALU result and flags; they hold until the next command's capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_z     <= '0;
            bus.res_flags <= '0;
        end else if (capt) begin
            bus.res_z                <= alu_z;
            bus.res_flags[FLG_CARRY] <= alu_carry;
            bus.res_flags[FLG_SIGN]  <= alu_sign;
            bus.res_flags[FLG_OV]    <= alu_ov;
        end
    end

    // Sticky overflow; an explicit clear beats a coincident overflowing writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.ov_sticky <= 1'b0;
        else if (bus.ov_clr)
            bus.ov_sticky <= 1'b0;
        else if (wb && bus.res_flags[FLG_OV])
            bus.ov_sticky <= 1'b1;
    end

    alu_regfile #(.W(W), .NREG(NREG)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (ra_q),
        .rb_addr (rb_q),
        .ra_data (rf_a),
        .rb_data (rf_b),
        .wb_en   (wb),
        .wb_addr (rd_q),
        .wb_data (bus.res_z),
        .ld_en   (bus.ld_valid),
        .ld_addr (bus.ld_addr),
        .ld_data (bus.ld_data)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and register-file model.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  alu_op;
    logic [11:0] alu_a, alu_b, alu_z;
    logic        alu_carry, alu_sign, alu_ov;

    alu_sequencer_if #(.W(12), .NREG(4)) bus ();

    alu_sequencer #(.W(12), .NREG(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_z     (alu_z),
        .alu_carry (alu_carry),
        .alu_sign  (alu_sign),
        .alu_ov    (alu_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU behaviour: returns {carry, sign, ov, z}.
    function automatic logic [14:0] alu_ref(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        logic [11:0] z;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            3'd0: begin z = a[11] ? (~a + 12'd1) : a; v = (a == 12'h800); end
            3'd1: begin z = {b[10:0], 1'b0}; c = b[11]; v = b[11] ^ b[10]; end
            3'd2: z = a & b;
            3'd3: z = a | b;
            3'd4: z = a ^ b;
            3'd5: z = ~a;
            3'd6: begin
                s = {1'b0, a} + {1'b0, b};
                z = s[11:0];
                c = s[12];
                v = (a[11] == b[11]) && (z[11] != a[11]);
            end
            default: begin
                z = a - b;
                c = (a < b);
                v = (a[11] != b[11]) && (z[11] != a[11]);
            end
        endcase
        return {c, z[11], v, z};
    endfunction

    // Combinational ALU attached to the sequencer's ALU bus.
    always_comb begin
        logic [14:0] r;
        r         = alu_ref(alu_op, alu_a, alu_b);
        alu_z     = r[11:0];
        alu_ov    = r[12];
        alu_sign  = r[13];
        alu_carry = r[14];
    end

    int          n_chk;
    int          n_pass;
    logic [11:0] m_rf [4];
    logic        m_ov;
    logic [11:0] got_z;
    logic [2:0]  got_f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m_rf[i] = '0;
        m_ov = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] addr, input logic [11:0] data);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = addr;
        bus.ld_data  = data;
        @(posedge clk);
        m_rf[addr] = data;
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic do_clr();
        bus.ov_clr = 1'b1;
        @(posedge clk);
        m_ov = 1'b0;
        @(negedge clk);
        bus.ov_clr = 1'b0;
    endtask

    task automatic drive_ld(input logic [1:0] addr, input logic [11:0] data);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = addr;
        bus.ld_data  = data;
    endtask

    // One command from IDLE; lph selects where a side load lands: 1 accept edge,
    // 2 ISSUE edge, 3 CAPT edge, 4 WB edge, 0 none.
    task automatic run_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                           input logic [1:0] rb, input int lph, input logic [1:0] la,
                           input logic [11:0] ldv, input bit clr_wb);
        logic [11:0] ea, eb, ez;
        logic [2:0]  ef;
        logic [14:0] r;
        int          n;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.cmd_ready) chk("ready_timeout", 0, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_ra    = ra;
        bus.cmd_rb    = rb;
        if (lph == 1) drive_ld(la, ldv);
        @(posedge clk);
        if (lph == 1) m_rf[la] = ldv;
        ea = (op == OP_SHL) ? 12'h000 : m_rf[ra];
        eb = (op == OP_ABS || op == OP_NOT) ? 12'h000 : m_rf[rb];
        r  = alu_ref(op, ea, eb);
        ez = r[11:0];
        ef = {r[14], r[13], r[12]};
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        chk("ready_issue", bus.cmd_ready, 0);
        chk("resv_issue", bus.res_valid, 0);
        if (lph == 2) drive_ld(la, ldv);
        @(posedge clk);
        if (lph == 2) m_rf[la] = ldv;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        chk("alu_op", alu_op, op);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("ready_capt", bus.cmd_ready, 0);
        if (lph == 3) drive_ld(la, ldv);
        @(posedge clk);
        if (lph == 3) m_rf[la] = ldv;
        @(negedge clk);
        bus.ld_valid = 1'b0;
        chk("resv_wb", bus.res_valid, 1);
        chk("ready_wb", bus.cmd_ready, 0);
        chk("res_z", bus.res_z, ez);
        chk("res_flags", bus.res_flags, ef);
        got_z = bus.res_z;
        got_f = bus.res_flags;
        if (lph == 4) drive_ld(la, ldv);
        if (clr_wb) bus.ov_clr = 1'b1;
        @(posedge clk);
        if (lph == 4) m_rf[la] = ldv;
        m_rf[rd] = ez;
        m_ov = clr_wb ? 1'b0 : (m_ov | ef[0]);
        @(negedge clk);
        bus.ld_valid = 1'b0;
        bus.ov_clr   = 1'b0;
        chk("resv_after", bus.res_valid, 0);
        chk("ready_after", bus.cmd_ready, 1);
        chk("ov_sticky", bus.ov_sticky, m_ov);
        chk("res_z_hold", bus.res_z, ez);
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [11:0] v);
        run_cmd(OP_OR, a, a, a, 0, 2'd0, 12'h000, 1'b0);
        v = got_z;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] z;
        logic [2:0]  f;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] v;
        n_chk = 0;
        n_pass = 0;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_rd = 0; bus.cmd_ra = 0; bus.cmd_rb = 0;
        bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0; bus.ov_clr = 0;

        vecs[0] = '{OP_ABS, 12'hFFD, 12'h123, 12'h003, 3'b000};
        vecs[1] = '{OP_SHL, 12'h555, 12'h801, 12'h002, 3'b101};
        vecs[2] = '{OP_AND, 12'hF0F, 12'h3C3, 12'h303, 3'b000};
        vecs[3] = '{OP_OR,  12'h0F0, 12'h801, 12'h8F1, 3'b010};
        vecs[4] = '{OP_XOR, 12'hFFF, 12'h0F0, 12'hF0F, 3'b010};
        vecs[5] = '{OP_NOT, 12'h0F0, 12'hABC, 12'hF0F, 3'b010};
        vecs[6] = '{OP_ADD, 12'h7FF, 12'h001, 12'h800, 3'b011};
        vecs[7] = '{OP_ADD, 12'hFFF, 12'h002, 12'h001, 3'b100};
        vecs[8] = '{OP_SUB, 12'h005, 12'h007, 12'hFFE, 3'b110};
        vecs[9] = '{OP_SUB, 12'h800, 12'h001, 12'h7FF, 3'b001};

        do_reset();
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_resv", bus.res_valid, 0);
        chk("rst_res_z", bus.res_z, 0);
        chk("rst_flags", bus.res_flags, 0);
        chk("rst_ov", bus.ov_sticky, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);

        // Table vectors: r3 = r1 op r2.
        for (int i = 0; i < 10; i++) begin
            do_load(2'd1, vecs[i].a);
            do_load(2'd2, vecs[i].b);
            run_cmd(vecs[i].op, 2'd3, 2'd1, 2'd2, 0, 2'd0, 12'h000, 1'b0);
            chk("vec_z", got_z, vecs[i].z);
            chk("vec_flags", got_f, vecs[i].f);
            read_reg(2'd3, v);
            chk("vec_rd", v, vecs[i].z);
            if (vecs[i].f[FLG_OV]) chk("vec_ov_set", bus.ov_sticky, 1);
            do_clr();
            chk("vec_ov_clr", bus.ov_sticky, 0);
        end

        // Unary op with rb pointing at a non-zero register.
        do_load(2'd0, 12'h0F0);
        do_load(2'd1, 12'hABC);
        run_cmd(OP_NOT, 2'd2, 2'd0, 2'd1, 0, 2'd0, 12'h000, 1'b0);
        chk("not_z", got_z, 12'hF0F);
        read_reg(2'd2, v);
        chk("not_r2", v, 12'hF0F);

        // Load collides with writeback to the same register.
        do_load(2'd1, 12'h005);
        do_load(2'd2, 12'h003);
        run_cmd(OP_ADD, 2'd0, 2'd1, 2'd2, 4, 2'd0, 12'h777, 1'b0);
        read_reg(2'd0, v);
        chk("coll_r0", v, 12'h008);

        // Late load to a source register is not seen by the in-flight command.
        do_load(2'd1, 12'h005);
        do_load(2'd2, 12'h007);
        run_cmd(OP_SUB, 2'd1, 2'd1, 2'd2, 3, 2'd2, 12'h001, 1'b0);
        chk("late_z", got_z, 12'hFFE);
        read_reg(2'd1, v);
        chk("late_r1", v, 12'hFFE);
        read_reg(2'd2, v);
        chk("late_r2", v, 12'h001);

        // Load on the accept edge is visible at ISSUE.
        do_load(2'd1, 12'h010);
        run_cmd(OP_ADD, 2'd3, 2'd1, 2'd1, 1, 2'd1, 12'h020, 1'b0);
        chk("early_z", got_z, 12'h040);

        // Overflow with clear coinciding with writeback: clear wins.
        do_load(2'd1, 12'h7FF);
        do_load(2'd2, 12'h001);
        run_cmd(OP_ADD, 2'd3, 2'd1, 2'd2, 0, 2'd0, 12'h000, 1'b1);
        chk("clr_wb_ov", bus.ov_sticky, 0);

        // Continuous cmd_valid: one accept every four cycles.
        begin
            int acc, pulses;
            acc = 0;
            pulses = 0;
            bus.cmd_valid = 1'b1;
            bus.cmd_op = OP_OR; bus.cmd_rd = 2'd0; bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd0;
            for (int i = 0; i < 16; i++) begin
                chk("hs_ready", bus.cmd_ready, (i % 4) == 0);
                chk("hs_resv", bus.res_valid, (i % 4) == 3);
                if (bus.cmd_ready) acc++;
                if (bus.res_valid) pulses++;
                @(posedge clk);
                @(negedge clk);
            end
            bus.cmd_valid = 1'b0;
            chk("hs_accepts", acc, 4);
            chk("hs_pulses", pulses, 4);
        end

        // Reset asserted during CAPT discards the command.
        do_load(2'd1, 12'h123);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = OP_ADD; bus.cmd_rd = 2'd0; bus.cmd_ra = 2'd1; bus.cmd_rb = 2'd1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", bus.cmd_ready, 1);
        chk("mid_rst_resv", bus.res_valid, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_res", bus.res_valid, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m_rf[i] = '0;
        m_ov = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_res", bus.res_valid, 0);
        end
        read_reg(2'd0, v);
        chk("mid_rst_r0", v, 12'h000);
        read_reg(2'd1, v);
        chk("mid_rst_r1", v, 12'h000);

        // Randomized commands with random side loads and clears.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0)
                do_load(2'($urandom_range(0, 3)), 12'($urandom));
            run_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
                    12'($urandom), $urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), v);
            chk("final_rf", v, m_rf[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven initiator for the team's 12-bit ALU block. It holds a 4-entry × 12-bit register file and accepts three-address commands (op, rd, ra, rb) over a valid/ready handshake. For each command it presents registered OP/A/B to the ALU, captures Z and flags, writes Z back to rd and reports the result. It sits between the lab's command source (testbench or front-panel controller) and the combinational ALU.

## Interface
- Parameters:
  - `W`, 12: datapath width; must match the ALU.
  - `NREG`, 4: register-file entries; addresses are log2(NREG) bits.
- Ports:
  - `clk` in 1: single clock, rising edge.
  - `rst_n` in 1: asynchronous, active-low reset.
  - `cmd_valid` in 1: command offered.
  - `cmd_ready` out 1: sequencer can accept a command.
  - `cmd_op` in 3: ALU operation code, 0..7.
  - `cmd_rd`, `cmd_ra`, `cmd_rb` in 2: destination and source register addresses.
  - `ld_valid` in 1: direct register load strobe.
  - `ld_addr` in 2: load address.
  - `ld_data` in W: load data.
  - `alu_op` out 3: operation code presented to the ALU.
  - `alu_a`, `alu_b` out W: operands presented to the ALU.
  - `alu_z` in W: ALU result.
  - `alu_carry`, `alu_sign`, `alu_ov` in 1: ALU flags.
  - `res_valid` out 1: one-cycle result pulse.
  - `res_z` out W: result value.
  - `res_flags` out 3: {carry, sign, ov} for this command.
  - `ov_sticky` out 1: OR of ov over all commands since reset or clear.
  - `ov_clr` in 1: clears `ov_sticky`.

## Operation
- Op encoding is fixed: 0 ABS(A), 1 B<<1, 2 AND, 3 OR, 4 XOR, 5 NOT(A), 6 ADD, 7 SUB.
- Ops 0 and 5 ignore B: `alu_b` is driven to 0. Op 1 ignores A: `alu_a` is driven to 0.
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid` the command is latched and the FSM goes to ISSUE.
  - ISSUE: `alu_op`/`alu_a`/`alu_b` are registered from the latched op and the register-file values. Go to CAPT.
  - CAPT: `alu_z` and flags are sampled into the result registers. Go to WB.
  - WB: `rf[rd]`←result, `res_valid`=1, `ov_sticky` |= ov. Go to IDLE.
- `cmd_ready` is 0 in ISSUE, CAPT and WB. There is no back-to-back accept; throughput is one command per 4 cycles.
- Register-file read happens at the ISSUE edge and uses register contents at that edge. Source operands are the values current at ISSUE, not at accept.
- Load port:
  - `ld_valid` writes `rf[ld_addr]` in any state.
  - If a load and WB target the same address in the same cycle, WB wins.
  - A load to ra/rb landing on the accept edge is not visible until ISSUE. A load landing in ISSUE or later is not used by the in-flight command.
- rd == ra or rd == rb is legal; the sources are already captured.
- `ov_clr` coinciding with WB: the clear wins, so `ov_sticky`=0 after that edge.
- `res_z` and `res_flags` hold their values until the next WB.
- `alu_op`/`alu_a`/`alu_b` hold until the next ISSUE.

## Timing
- Accept edge = cycle 0.
  - `alu_*` valid after edge 1.
  - Capture at edge 2.
  - `res_valid` high for the cycle after edge 2, with rf write at edge 3.
  - Latency from accept to `res_valid` is 3 cycles.
- The ALU is combinational; it has one full cycle (ISSUE→CAPT) from registered `alu_*` to capture.
- Reset (asynchronous, any state, including mid-command):
  - FSM returns to IDLE.
  - All rf entries 0.
  - `cmd_ready`=1.
  - `alu_op`/`alu_a`/`alu_b`=0.
  - `res_valid`=0, `res_z`=0, `res_flags`=0, `ov_sticky`=0.
  - The in-flight command is discarded with no writeback.

## Structure
- Shared package (`alu_pkg`) holds:
  - W.
  - Op-code localparams (OP_ABS … OP_SUB).
  - FSM state enum {IDLE, ISSUE, CAPT, WB}.
  - Flag bit indices (FLG_CARRY=2, FLG_SIGN=1, FLG_OV=0).
- Natural sub-module: `alu_regfile`, with 2 async read ports, 2 write ports and a fixed priority (WB over load).
- The ALU itself is instantiated next to this block at top level, not inside it.

## Test plan
- Reset mid-command:
  - Stimulus: load r1=0x123, issue ADD r0=r1+r1, assert `rst_n`=0 in CAPT.
  - Required: no `res_valid`, r0=0, r1=0, `cmd_ready`=1 immediately.
- Overflow and sticky clear:
  - Stimulus: load r1=0x7FF, r2=0x001, then ADD r3=r1+r2.
  - Required: `res_valid` 3 cycles after accept, `res_z`=0x800, `res_flags`=3'b011, `ov_sticky`=1. Then `ov_clr` → `ov_sticky`=0.
- Unary op:
  - Stimulus: load r0=0x0F0, r1=0xABC, then NOT r2=r0 (rb=r1).
  - Required: `alu_b`=0 during the command, `res_z`=0xF0F, r2=0xF0F.
- Writeback collision:
  - Stimulus: ADD r0=r1+r2 with r1=0x005, r2=0x003, with `ld_valid` to r0=0x777 on the WB cycle.
  - Required: r0=0x008.
- Late load not used:
  - Stimulus: accept SUB r1=r1-r2 (r1=0x005, r2=0x007), load r2=0x001 during CAPT.
  - Required: `res_z`=0xFFE and r1=0xFFE, computed with the old r2. Subsequent read of r2 returns 0x001.
- Handshake:
  - Stimulus: hold `cmd_valid` high continuously.
  - Required: exactly one accept per 4 cycles, and `cmd_ready` low in ISSUE/CAPT/WB.
